ledger_validator: RTL and testbench

Parametrised successor to the single-channel transaction validator: it accepts 128-bit transfer records, looks up or creates the sender and receiver accounts in an on-chip ledger, and checks funds. It commits balances and returns every transaction with an accept/reject verdict. Depth, balance width, initial balance and scan parallelism are parameters. It adds ready/valid backpressure on both sides, reject reason codes, ledger-full and self-transfer handling, and optional statistics. It sits between the packet parser and the output packer.

---
 rtl/ledger_validator.sv | 248 ++++++++++++++++++++++++
 tb/tb_ledger_validator.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ledger_validator.sv
// ledger_validator: validates 128-bit transfer records against an on-chip account ledger.
// Define LEDGER_STATS_EN to add the stat_acc_o / stat_rej_o result counters.
module ledger_validator #(
  parameter int unsigned DEPTH    = 16384,
  parameter int unsigned LANES    = 2,
  parameter int unsigned BAL_W    = 24,
  parameter int unsigned INIT_BAL = 100
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] data_i,
  input  logic         valid_i,
  output logic         ready_o,
  output logic [127:0] data_o,
  output logic         valid_o,
  input  logic         ready_i,
  output logic         reject_o,
  output logic [1:0]   reason_o
`ifdef LEDGER_STATS_EN
  ,
  output logic [31:0]  stat_acc_o,
  output logic [31:0]  stat_rej_o
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = 48 + BAL_W;

  typedef enum logic [2:0] {IDLE, SCAN, ALLOC, CHECK, WR_S, WR_R, OUT} state_t;
  state_t state, state_nx;

  logic [EW-1:0]    mem [DEPTH];
  logic             we;
  logic [AW-1:0]    wa;
  logic [EW-1:0]    wd;

  logic [127:0]     rec;
  logic [CW-1:0]    cnt, base, rd_base_q;
  logic             rd_pend;
  logic             s_found, r_found, r_new, rej;
  logic [AW-1:0]    s_ptr, r_ptr;
  logic [BAL_W-1:0] s_bal, r_bal, amt;
  logic [1:0]       reason, missing;
  logic [47:0]      s_id, r_id;
  logic             issue, scan_done, self_xfer, no_room, accept;
  logic [BAL_W:0]   r_sum;

  logic [LANES:0]             hs_c, hr_c;
  logic [LANES:0][AW-1:0]     sp_c, rp_c;
  logic [LANES:0][BAL_W-1:0]  sb_c, rb_c;

  assign s_id      = rec[127:80];
  assign r_id      = rec[79:32];
  assign amt       = BAL_W'(rec[31:10]);
  assign data_o    = rec;
  assign reject_o  = rej;
  assign reason_o  = reason;
  assign issue     = base < cnt;
  assign self_xfer = s_id == r_id;
  assign missing   = {1'b0, !s_found} + {1'b0, !r_found};
  assign no_room   = CW'(missing) > (CW'(DEPTH) - cnt);
  assign accept    = !rej && (s_bal >= amt);
  assign r_sum     = {1'b0, r_bal} + {1'b0, amt};

  assign hs_c[0] = 1'b0;
  assign hr_c[0] = 1'b0;
  assign sp_c[0] = '0;
  assign rp_c[0] = '0;
  assign sb_c[0] = '0;
  assign rb_c[0] = '0;

  // Each lane has its own registered read port; hits are folded lane by lane.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [EW-1:0] q;
    logic [CW-1:0] idx;
    logic          live, hs, hr;

    always_ff @(posedge clk)
      if (state == SCAN && issue) q <= mem[base[AW-1:0] + AW'(g)];

    assign idx  = rd_base_q + CW'(g);
    assign live = rd_pend && (idx < cnt);
    assign hs   = live && (q[EW-1:BAL_W] == s_id);
    assign hr   = live && (q[EW-1:BAL_W] == r_id);
    assign hs_c[g+1] = hs_c[g] | hs;
    assign hr_c[g+1] = hr_c[g] | hr;
    assign sp_c[g+1] = hs ? idx[AW-1:0] : sp_c[g];
    assign rp_c[g+1] = hr ? idx[AW-1:0] : rp_c[g];
    assign sb_c[g+1] = hs ? q[BAL_W-1:0] : sb_c[g];
    assign rb_c[g+1] = hr ? q[BAL_W-1:0] : rb_c[g];
  end

  assign scan_done = ((hs_c[LANES] | s_found) & (hr_c[LANES] | r_found)) | !issue;

  always_ff @(posedge clk)
    if (we) mem[wa] <= wd;

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nx;

  always_comb begin
    state_nx = state;
    ready_o  = 1'b0;
    valid_o  = 1'b0;
    we       = 1'b0;
    wa       = '0;
    wd       = '0;
    unique case (state)
      IDLE: begin
        ready_o = 1'b1;
        if (valid_i) state_nx = SCAN;
      end
      SCAN: if (scan_done) state_nx = ALLOC;
      // New accounts are written with INIT_BAL immediately so that an account
      // kept by a funds reject holds a defined entry; accepts overwrite it later.
      ALLOC: begin
        state_nx = CHECK;
        if (!self_xfer && !no_room && !s_found) begin
          we = 1'b1;
          wa = cnt[AW-1:0];
          wd = {s_id, BAL_W'(INIT_BAL)};
        end
      end
      CHECK: begin
        state_nx = accept ? WR_S : OUT;
        if (r_new) begin
          we = 1'b1;
          wa = r_ptr;
          wd = {r_id, BAL_W'(INIT_BAL)};
        end
      end
      WR_S: begin
        state_nx = WR_R;
        we = 1'b1;
        wa = s_ptr;
        wd = {s_id, s_bal};
      end
      WR_R: begin
        state_nx = OUT;
        we = 1'b1;
        wa = r_ptr;
        wd = {r_id, r_bal};
      end
      OUT: begin
        valid_o = 1'b1;
        if (ready_i) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rec       <= '0;
      cnt       <= '0;
      base      <= '0;
      rd_base_q <= '0;
      rd_pend   <= 1'b0;
      s_found   <= 1'b0;
      r_found   <= 1'b0;
      r_new     <= 1'b0;
      rej       <= 1'b0;
      reason    <= '0;
      s_ptr     <= '0;
      r_ptr     <= '0;
      s_bal     <= '0;
      r_bal     <= '0;
    end else begin
      unique case (state)
        IDLE: if (valid_i) begin
          rec     <= data_i;
          base    <= '0;
          rd_pend <= 1'b0;
          s_found <= 1'b0;
          r_found <= 1'b0;
          r_new   <= 1'b0;
          rej     <= 1'b0;
          reason  <= '0;
          if (data_i[9]) cnt <= '0;
        end
        SCAN: begin
          rd_pend   <= issue;
          rd_base_q <= base;
          if (issue) base <= base + CW'(LANES);
          if (hs_c[LANES]) begin
            s_found <= 1'b1;
            s_ptr   <= sp_c[LANES];
            s_bal   <= sb_c[LANES];
          end
          if (hr_c[LANES]) begin
            r_found <= 1'b1;
            r_ptr   <= rp_c[LANES];
            r_bal   <= rb_c[LANES];
          end
        end
        ALLOC: begin
          rd_pend <= 1'b0;
          if (self_xfer) begin
            rej    <= 1'b1;
            reason <= 2'd3;
          end else if (no_room) begin
            rej    <= 1'b1;
            reason <= 2'd2;
          end else begin
            if (!s_found) begin
              s_ptr <= cnt[AW-1:0];
              s_bal <= BAL_W'(INIT_BAL);
            end
            if (!r_found) begin
              r_ptr <= cnt[AW-1:0] + AW'(!s_found);
              r_bal <= BAL_W'(INIT_BAL);
              r_new <= 1'b1;
            end
            cnt <= cnt + CW'(missing);
          end
        end
        CHECK: if (!rej) begin
          if (s_bal >= amt) begin
            s_bal <= s_bal - amt;
            r_bal <= r_sum[BAL_W] ? '1 : r_sum[BAL_W-1:0];
          end else begin
            rej    <= 1'b1;
            reason <= 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef LEDGER_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_acc_o <= '0;
      stat_rej_o <= '0;
    end else if (state == IDLE && valid_i && data_i[9]) begin
      stat_acc_o <= '0;
      stat_rej_o <= '0;
    end else if (valid_o && ready_i) begin
      if (rej) stat_rej_o <= stat_rej_o + 32'd1;
      else     stat_acc_o <= stat_acc_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ledger_validator.sv
// tb_ledger_validator: table-driven scoreboard bench for ledger_validator (default and DEPTH=4 builds).
module tb_ledger_validator;

  localparam int unsigned BIG_INIT = 16777116;

  logic clk = 1'b0;
  logic rst;
  logic ready_i;
  logic [127:0] din;
  logic [1:0] vld, rdy, vout, rej;
  logic [1:0][127:0] dout;
  logic [1:0][1:0] rsn;
`ifdef LEDGER_STATS_EN
  logic [1:0][31:0] sacc, srej;
`endif

  int n_chk = 0;
  int n_fail = 0;
  int wr0 = 0;
  int wr1 = 0;

  always #5 clk = ~clk;

  ledger_validator dut (
`ifdef LEDGER_STATS_EN
    .stat_acc_o(sacc[0]), .stat_rej_o(srej[0]),
`endif
    .clk(clk), .rst(rst), .data_i(din), .valid_i(vld[0]), .ready_o(rdy[0]),
    .data_o(dout[0]), .valid_o(vout[0]), .ready_i(ready_i),
    .reject_o(rej[0]), .reason_o(rsn[0]));

  ledger_validator #(.DEPTH(4), .INIT_BAL(BIG_INIT)) dut4 (
`ifdef LEDGER_STATS_EN
    .stat_acc_o(sacc[1]), .stat_rej_o(srej[1]),
`endif
    .clk(clk), .rst(rst), .data_i(din), .valid_i(vld[1]), .ready_o(rdy[1]),
    .data_o(dout[1]), .valid_o(vout[1]), .ready_i(ready_i),
    .reject_o(rej[1]), .reason_o(rsn[1]));

  always @(negedge clk) begin
    if (dut.we)  wr0++;
    if (dut4.we) wr1++;
  end

  typedef struct {
    logic [127:0] data;
    logic         rej;
    logic [1:0]   rsn;
    int           lat;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    bit          sel;
    logic [47:0] s;
    logic [47:0] r;
    logic [21:0] amt;
    bit          bs;
    bit          rej;
    logic [1:0]  rsn;
    int          lat;
    int          cnt;
  } vec_t;
  vec_t vt [16];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic send(input int sel, input logic [47:0] s, input logic [47:0] r,
                      input logic [21:0] a, input logic bs, input logic xrej,
                      input logic [1:0] xrsn, input int xlat);
    exp_t e;
    logic [8:0] low;
    low = 9'($urandom);
    din = {s, r, a, bs, low};
    check("ready_before_send", 128'(rdy[sel]), 128'd1);
    e.data = din;
    e.rej  = xrej;
    e.rsn  = xrsn;
    e.lat  = xlat;
    sbq.push_back(e);
    vld[sel] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vld[sel] = 1'b0;
  endtask

  task automatic wait_out(input int sel, output int lat);
    lat = 0;
    while (!vout[sel] && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    if (!vout[sel]) begin
      n_chk++;
      n_fail++;
      $display("FAIL valid_timeout: valid_o still 0 after %0d cycles", lat);
    end
  endtask

  task automatic check_out(input int sel, input int lat);
    exp_t e;
    if (sbq.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL scoreboard_empty: result with nothing expected");
      return;
    end
    e = sbq.pop_front();
    check("latency", 128'(lat), 128'(e.lat));
    check("data_o", dout[sel], e.data);
    check("reject_o", 128'(rej[sel]), 128'(e.rej));
    check("reason_o", 128'(rsn[sel]), 128'(e.rsn));
  endtask

  task automatic take(input int sel);
    ready_i = 1'b1;
    @(negedge clk);
    check("valid_after_take", 128'(vout[sel]), 128'd0);
    check("ready_after_take", 128'(rdy[sel]), 128'd1);
  endtask

  initial begin
    int lat, w, bad;
    logic [127:0] snap;

    vt[0]  = '{1'b0, 48'h1,  48'h2,  22'd30,      1'b1, 1'b0, 2'd0, 5, 2};
    vt[1]  = '{1'b0, 48'h2,  48'h1,  22'd200,     1'b0, 1'b1, 2'd1, 4, 2};
    vt[2]  = '{1'b0, 48'h2,  48'h1,  22'd130,     1'b0, 1'b0, 2'd0, 6, 2};
    vt[3]  = '{1'b0, 48'h2,  48'h1,  22'd1,       1'b0, 1'b1, 2'd1, 4, 2};
    vt[4]  = '{1'b0, 48'h1,  48'h2,  22'd200,     1'b0, 1'b0, 2'd0, 6, 2};
    vt[5]  = '{1'b0, 48'h1,  48'h1,  22'd1,       1'b0, 1'b1, 2'd3, 4, 2};
    vt[6]  = '{1'b0, 48'h3,  48'h4,  22'd50,      1'b0, 1'b0, 2'd0, 6, 4};
    vt[7]  = '{1'b0, 48'h4,  48'h1,  22'd150,     1'b0, 1'b0, 2'd0, 7, 4};
    vt[8]  = '{1'b0, 48'h3,  48'h5,  22'd101,     1'b0, 1'b1, 2'd1, 5, 5};
    vt[9]  = '{1'b0, 48'h1,  48'h2,  22'd10,      1'b0, 1'b0, 2'd0, 6, 5};
    vt[10] = '{1'b1, 48'h10, 48'h11, 22'd200,     1'b1, 1'b0, 2'd0, 5, 2};
    vt[11] = '{1'b1, 48'h12, 48'h13, 22'd0,       1'b0, 1'b0, 2'd0, 6, 4};
    vt[12] = '{1'b1, 48'h14, 48'h15, 22'd5,       1'b0, 1'b1, 2'd2, 5, 4};
    vt[13] = '{1'b1, 48'h12, 48'h10, 22'd1,       1'b0, 1'b0, 2'd0, 7, 4};
    vt[14] = '{1'b1, 48'h14, 48'h10, 22'd1,       1'b0, 1'b1, 2'd2, 5, 4};
    vt[15] = '{1'b1, 48'h11, 48'h13, 22'h3FFFFF,  1'b0, 1'b0, 2'd0, 7, 4};

    rst = 1'b1;
    ready_i = 1'b1;
    vld = '0;
    din = '0;
    repeat (3) @(negedge clk);
    check("reset_ready", {126'd0, rdy}, 128'd3);
    check("reset_valid", {126'd0, vout}, 128'd0);
    check("reset_reject", {126'd0, rej}, 128'd0);
    check("reset_reason", {124'd0, rsn}, 128'd0);
    check("reset_data", dout[0] | dout[1], 128'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      int sel;
      sel = int'(vt[i].sel);
      w = sel ? wr1 : wr0;
      send(sel, vt[i].s, vt[i].r, vt[i].amt, vt[i].bs, vt[i].rej, vt[i].rsn, vt[i].lat);
      wait_out(sel, lat);
      check_out(sel, lat);
      take(sel);
      check("ledger_cnt", 128'(sel ? dut4.cnt : dut.cnt), 128'(vt[i].cnt));
      if (vt[i].rsn >= 2'd2)
        check("no_writes_on_reject", 128'((sel ? wr1 : wr0) - w), 128'd0);
      if (i == 0) begin
        check("ledger_a_70", 128'(dut.mem[0]), {56'd0, 48'h1, 24'd70});
        check("ledger_b_130", 128'(dut.mem[1]), {56'd0, 48'h2, 24'd130});
      end
      if (i == 10) begin
        check("ledger_sender_big", 128'(dut4.mem[0]), {56'd0, 48'h10, 24'd16776916});
        check("ledger_recv_sat", 128'(dut4.mem[1]), {56'd0, 48'h11, 24'hFFFFFF});
      end
    end

    // Output stall: result must hold while ready_i is low.
    ready_i = 1'b0;
    send(0, 48'h1, 48'h1, 22'd1, 1'b0, 1'b1, 2'd3, 4);
    wait_out(0, lat);
    check_out(0, lat);
    snap = dout[0];
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (!vout[0] || rdy[0] || dout[0] !== snap || rsn[0] !== 2'd3 || rej[0] !== 1'b1) bad++;
    end
    check("stall_hold", 128'(bad), 128'd0);
    take(0);

    // Grow the main ledger to 50 entries; each new pair scans one more group.
    for (int i = 0; i < 25; i++) begin
      send(0, 48'h100 + 48'(2 * i), 48'h101 + 48'(2 * i), 22'd1, i == 0, 1'b0, 2'd0, i + 5);
      wait_out(0, lat);
      check_out(0, lat);
      take(0);
    end
    check("cnt_50", 128'(dut.cnt), 128'd50);

    // Reset in the middle of a long scan.
    din = {48'hA0, 48'hB0, 22'd30, 1'b0, 9'h1A5};
    vld[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vld[0] = 1'b0;
    repeat (5) @(negedge clk);
    check("busy_before_reset", 128'({rdy[0], vout[0]}), 128'd0);
    #2 rst = 1'b1;
    #1;
    check("async_rst_ready", 128'(rdy[0]), 128'd1);
    check("async_rst_valid", 128'(vout[0]), 128'd0);
    check("async_rst_rej_rsn", 128'({rej[0], rsn[0]}), 128'd0);
    check("async_rst_data", dout[0], 128'd0);
    check("async_rst_cnt", 128'(dut.cnt), 128'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send(0, 48'hA0, 48'hB0, 22'd30, 1'b0, 1'b0, 2'd0, 5);
    wait_out(0, lat);
    check_out(0, lat);
    take(0);
    check("post_rst_cnt", 128'(dut.cnt), 128'd2);
    check("post_rst_a", 128'(dut.mem[0]), {56'd0, 48'hA0, 24'd70});
    check("post_rst_b", 128'(dut.mem[1]), {56'd0, 48'hB0, 24'd130});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
